// File: rtl/alu_ctrl.sv
// alu_ctrl: sequencer sitting between instruction decode and the shared
// DATASIZE-bit ALU. It accepts one request at a time, drives the ALU select,
// operand and flag-in lines, and captures the ALU result and flags into its
// own result/flag registers. Byte ops take one ALU pass. DAD/DSUB take two
// passes (low byte, then high byte with the carry chained through a
// temporary flag register).
//
// Ports:
//   iClk, iRst        clock (rising edge), asynchronous active-high reset
//   iGo, iOp, iA, iB  request strobe, opcode and 16-bit operands (IDLE only)
//   iFLd, iFD         flag register load (IDLE only, wins over iGo)
//   oS, oA, oB, oFin  ALU select, operands, flag input (carry-in source)
//   iY, iF            ALU result and flag output
//   oRes, oFlg        result and flag registers
//   oBusy             high in every state except IDLE
//   oDone, oErr       one-cycle completion pulse, reserved-opcode error
module alu_ctrl #(
  parameter int DATASIZE = 8,
  parameter int FLAG_Z   = 6,
  parameter int FLAG_C   = 0
) (
  input  logic                  iClk,
  input  logic                  iRst,
  input  logic                  iGo,
  input  logic [3:0]            iOp,
  input  logic [2*DATASIZE-1:0] iA,
  input  logic [2*DATASIZE-1:0] iB,
  input  logic                  iFLd,
  input  logic [DATASIZE-1:0]   iFD,
  output logic [2:0]            oS,
  output logic [DATASIZE-1:0]   oA,
  output logic [DATASIZE-1:0]   oB,
  output logic [DATASIZE-1:0]   oFin,
  input  logic [DATASIZE-1:0]   iY,
  input  logic [DATASIZE-1:0]   iF,
  output logic [2*DATASIZE-1:0] oRes,
  output logic [DATASIZE-1:0]   oFlg,
  output logic                  oBusy,
  output logic                  oDone,
  output logic                  oErr
);

  localparam logic [2:0] SEL_ADD = 3'b000;
  localparam logic [2:0] SEL_ADC = 3'b001;
  localparam logic [2:0] SEL_SUB = 3'b010;
  localparam logic [2:0] SEL_SBB = 3'b011;
  localparam logic [2:0] SEL_CMP = 3'b111;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    EXEC = 3'd1,
    LO   = 3'd2,
    HI   = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t                state;
  state_t                nextState;
  logic                  accept;
  logic                  reservedOp;
  logic                  errQ;
  logic [2:0]            opSel;
  logic [2*DATASIZE-1:0] aQ;
  logic [2*DATASIZE-1:0] bQ;
  logic [DATASIZE-1:0]   tmpFlg;
  logic [DATASIZE-1:0]   dadFlg;
  logic [DATASIZE-1:0]   dsubFlg;

  // A flag load in IDLE takes priority over a request in the same cycle.
  assign accept     = (state == IDLE) && !iFLd && iGo;
  assign reservedOp = iOp[3] && (iOp[2:1] != 2'b00);

  // DAD only reports the final carry; the other flags keep their old values.
  // DSUB reports the high-byte flags but Z must reflect the whole 16 bits.
  always_comb begin
    dadFlg          = oFlg;
    dadFlg[FLAG_C]  = iF[FLAG_C];
    dsubFlg         = iF;
    dsubFlg[FLAG_Z] = tmpFlg[FLAG_Z] & iF[FLAG_Z];
  end

  // Operand capture: only opSel[0] distinguishes DAD from DSUB once the
  // request has been routed, so opcode bit 3 need not be kept.
  always_ff @(posedge iClk) begin
    if (accept) begin
      opSel <= iOp[2:0];
      aQ    <= iA;
      bQ    <= iB;
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      oRes   <= '0;
      oFlg   <= '0;
      tmpFlg <= '0;
      errQ   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (iFLd) begin
            oFlg <= iFD;
          end else if (iGo) begin
            errQ <= reservedOp;
          end
        end
        EXEC: begin
          oFlg <= iF;
          if (opSel != SEL_CMP) begin
            oRes[DATASIZE-1:0] <= iY;
          end
        end
        LO: begin
          oRes[DATASIZE-1:0] <= iY;
          tmpFlg             <= iF;
        end
        HI: begin
          oRes[2*DATASIZE-1:DATASIZE] <= iY;
          oFlg                        <= opSel[0] ? dsubFlg : dadFlg;
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    nextState = state;
    oS        = SEL_ADD;
    oA        = '0;
    oB        = '0;
    oFin      = oFlg;
    case (state)
      IDLE: begin
        if (accept) begin
          if (!iOp[3]) begin
            nextState = EXEC;
          end else if (!reservedOp) begin
            nextState = LO;
          end else begin
            nextState = DONE;
          end
        end
      end
      EXEC: begin
        oS        = opSel;
        oA        = aQ[DATASIZE-1:0];
        oB        = bQ[DATASIZE-1:0];
        nextState = DONE;
      end
      LO: begin
        oS        = opSel[0] ? SEL_SUB : SEL_ADD;
        oA        = aQ[DATASIZE-1:0];
        oB        = bQ[DATASIZE-1:0];
        nextState = HI;
      end
      HI: begin
        // High byte chains the low-byte carry/borrow via the temp flags.
        oS        = opSel[0] ? SEL_SBB : SEL_ADC;
        oA        = aQ[2*DATASIZE-1:DATASIZE];
        oB        = bQ[2*DATASIZE-1:DATASIZE];
        oFin      = tmpFlg;
        nextState = DONE;
      end
      DONE: begin
        nextState = IDLE;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  assign oBusy = (state != IDLE);
  assign oDone = (state == DONE);
  assign oErr  = (state == DONE) && errQ;

endmodule

// File: tb/tb_alu_ctrl.sv
// Directed bench for alu_ctrl. A behavioural 8080-style ALU answers the
// controller's select/operand lines; expected results are queued when each
// request is issued and compared when oDone appears.
module tb_alu_ctrl;

  logic        iClk = 1'b0;
  logic        iRst;
  logic        iGo;
  logic [3:0]  iOp;
  logic [15:0] iA;
  logic [15:0] iB;
  logic        iFLd;
  logic [7:0]  iFD;
  logic [2:0]  oS;
  logic [7:0]  oA;
  logic [7:0]  oB;
  logic [7:0]  oFin;
  logic [7:0]  iY;
  logic [7:0]  iF;
  logic [15:0] oRes;
  logic [7:0]  oFlg;
  logic        oBusy;
  logic        oDone;
  logic        oErr;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [15:0] res;
    logic [7:0]  flg;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb[$];

  alu_ctrl #(.DATASIZE(8), .FLAG_Z(6), .FLAG_C(0)) dut (
    .iClk (iClk),
    .iRst (iRst),
    .iGo  (iGo),
    .iOp  (iOp),
    .iA   (iA),
    .iB   (iB),
    .iFLd (iFLd),
    .iFD  (iFD),
    .oS   (oS),
    .oA   (oA),
    .oB   (oB),
    .oFin (oFin),
    .iY   (iY),
    .iF   (iF),
    .oRes (oRes),
    .oFlg (oFlg),
    .oBusy(oBusy),
    .oDone(oDone),
    .oErr (oErr)
  );

  always #5 iClk = ~iClk;

  // Flag byte: S=7 Z=6 AC=4 P=2 C=0; returns {Y, F}.
  function automatic logic [15:0] aluModel(input logic [2:0] s, input logic [7:0] a,
                                           input logic [7:0] b, input logic [7:0] fin);
    int          ai;
    int          bi;
    int          ci;
    int          r;
    logic [7:0]  y;
    logic        cy;
    logic        h;
    ai = int'(a);
    bi = int'(b);
    ci = 0;
    y  = 8'h00;
    cy = 1'b0;
    h  = 1'b0;
    case (s)
      3'd0, 3'd1: begin
        if (s == 3'd1) ci = int'(fin[0]);
        r  = ai + bi + ci;
        y  = r[7:0];
        cy = (r > 255);
        h  = (((ai & 15) + (bi & 15) + ci) > 15);
      end
      3'd2, 3'd3, 3'd7: begin
        if (s == 3'd3) ci = int'(fin[0]);
        r  = ai - bi - ci;
        y  = r[7:0];
        cy = (r < 0);
        h  = ((ai & 15) < ((bi & 15) + ci));
      end
      3'd4: y = a & b;
      3'd5: y = a ^ b;
      default: y = a | b;
    endcase
    return {y, y[7], (y == 8'h00), 1'b0, h, 1'b0, ~^y, 1'b0, cy};
  endfunction

  always_comb {iY, iF} = aluModel(oS, oA, oB, oFin);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic loadFlags(input logic [7:0] v);
    iFLd = 1'b1;
    iFD  = v;
    @(posedge iClk); #1;
    iFLd = 1'b0;
    chk("flag load", {24'd0, oFlg}, {24'd0, v});
  endtask

  // Issue one request, scramble the operand inputs after acceptance, then
  // wait (bounded) for oDone and compare against the queued expectation.
  task automatic runOp(input string tag, input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] eRes, input logic [7:0] eFlg,
                       input logic eErr, input int eLat, input bit hold);
    exp_t e;
    int   lat;
    bit   got;
    int   extra;
    e.res = eRes;
    e.flg = eFlg;
    e.err = eErr;
    e.lat = eLat;
    sb.push_back(e);
    iOp = op;
    iA  = a;
    iB  = b;
    iGo = 1'b1;
    @(posedge iClk); #1;
    if (!hold) iGo = 1'b0;
    iOp = 4'($urandom);
    iA  = 16'($urandom);
    iB  = 16'($urandom);
    lat = 1;
    got = 1'b0;
    while (!got && lat < 8) begin
      if (oDone) got = 1'b1;
      else begin
        @(posedge iClk); #1;
        lat++;
      end
    end
    chk({tag, " done"}, 32'(got), 32'd1);
    e = sb.pop_front();
    if (got) begin
      chk({tag, " latency"}, 32'(lat), 32'(e.lat));
      chk({tag, " res"}, {16'd0, oRes}, {16'd0, e.res});
      chk({tag, " flg"}, {24'd0, oFlg}, {24'd0, e.flg});
      chk({tag, " err"}, 32'(oErr), 32'(e.err));
    end
    @(posedge iClk); #1;
    iGo = 1'b0;
    chk({tag, " idle after"}, 32'(oBusy), 32'd0);
    if (hold) begin
      extra = 0;
      for (int i = 0; i < 4; i++) begin
        @(posedge iClk); #1;
        if (oDone || oBusy) extra++;
      end
      chk({tag, " single op"}, 32'(extra), 32'd0);
    end
  endtask

  initial begin
    int seen;
    iRst = 1'b1;
    iGo  = 1'b0;
    iOp  = 4'h0;
    iA   = 16'h0;
    iB   = 16'h0;
    iFLd = 1'b0;
    iFD  = 8'h00;
    #8;
    chk("reset res", {16'd0, oRes}, 32'd0);
    chk("reset flg", {24'd0, oFlg}, 32'd0);
    chk("reset busy", 32'(oBusy), 32'd0);
    chk("reset done", 32'(oDone), 32'd0);
    chk("reset err", 32'(oErr), 32'd0);
    #4 iRst = 1'b0;
    @(posedge iClk); #1;

    loadFlags(8'h00);
    runOp("ADD", 4'h0, 16'h003A, 16'h00C6, 16'h0000, 8'h55, 1'b0, 2, 1'b0);
    loadFlags(8'h01);
    runOp("ADC", 4'h1, 16'h00FF, 16'h0000, 16'h0000, 8'h55, 1'b0, 2, 1'b0);
    runOp("XOR", 4'h5, 16'h005A, 16'h000F, 16'h0055, 8'h04, 1'b0, 2, 1'b0);
    loadFlags(8'hC5);
    runOp("DAD1", 4'h8, 16'h12FF, 16'h0001, 16'h1300, 8'hC4, 1'b0, 3, 1'b0);
    runOp("CMP", 4'h7, 16'h0010, 16'h0020, 16'h1300, 8'h85, 1'b0, 2, 1'b0);
    loadFlags(8'hC4);
    runOp("DAD2", 4'h8, 16'hFFFF, 16'h0001, 16'h0000, 8'hC5, 1'b0, 3, 1'b0);
    runOp("DSUB1", 4'h9, 16'h0100, 16'h0001, 16'h00FF, 8'h04, 1'b0, 3, 1'b0);
    runOp("DSUB2", 4'h9, 16'h1234, 16'h1234, 16'h0000, 8'h44, 1'b0, 3, 1'b0);
    runOp("DSUB3", 4'h9, 16'h0000, 16'h0001, 16'hFFFF, 8'h95, 1'b0, 3, 1'b0);
    runOp("DADHOLD", 4'h8, 16'h0102, 16'h0304, 16'h0406, 8'h94, 1'b0, 3, 1'b1);

    // Flag load and request together: load wins, nothing starts.
    iFLd = 1'b1;
    iFD  = 8'h2A;
    iGo  = 1'b1;
    iOp  = 4'h0;
    iA   = 16'h0001;
    iB   = 16'h0001;
    @(posedge iClk); #1;
    iFLd = 1'b0;
    iGo  = 1'b0;
    chk("go+fld flg", {24'd0, oFlg}, 32'h2A);
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (oDone || oBusy) seen++;
      @(posedge iClk); #1;
    end
    chk("go+fld no op", 32'(seen), 32'd0);
    chk("go+fld res", {16'd0, oRes}, 32'h0406);

    runOp("RSV", 4'hC, 16'h1111, 16'h2222, 16'h0406, 8'h2A, 1'b1, 1, 1'b0);

    // Asynchronous reset in the middle of a DAD high-byte pass.
    iOp = 4'h8;
    iA  = 16'h5555;
    iB  = 16'h1111;
    iGo = 1'b1;
    @(posedge iClk); #1;
    iGo = 1'b0;
    @(posedge iClk); #1;
    chk("pre-reset busy", 32'(oBusy), 32'd1);
    chk("pre-reset lo res", {16'd0, oRes}, 32'h0466);
    #2 iRst = 1'b1;
    #1;
    chk("async res", {16'd0, oRes}, 32'd0);
    chk("async flg", {24'd0, oFlg}, 32'd0);
    chk("async busy", 32'(oBusy), 32'd0);
    chk("async done", 32'(oDone), 32'd0);
    #2 iRst = 1'b0;
    @(posedge iClk); #1;
    chk("post-reset idle", 32'(oBusy), 32'd0);
    runOp("ADDPOST", 4'h0, 16'h0001, 16'h0002, 16'h0003, 8'h04, 1'b0, 2, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
